// File: rtl/mix_muldiv.sv
// Multi-cycle sign-magnitude multiply/divide unit for the MIX datapath.
// One shift-add (MUL) or restoring-division (DIV) step per cycle over an M-bit magnitude.
module mix_muldiv #(
    parameter int WORD_BYTES = 5,
    parameter int BYTE_BITS  = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              op,
    input  logic [WORD_BYTES*BYTE_BITS:0]     a,
    input  logic [WORD_BYTES*BYTE_BITS:0]     x,
    input  logic [WORD_BYTES*BYTE_BITS:0]     v,
    output logic                              busy,
    output logic                              stop,
    output logic [WORD_BYTES*BYTE_BITS:0]     out_a,
    output logic [WORD_BYTES*BYTE_BITS:0]     out_x,
    output logic                              overflow
);
    localparam int M  = WORD_BYTES * BYTE_BITS;
    localparam int CW = $clog2(M + 1);

    // Handshake: start is a one-cycle request honoured only in S_IDLE; busy covers
    // every cycle after the accept edge up to and including the single stop cycle.
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [M-1:0]   hi, lo, mcand;
    logic           sa, sv, sx;

    logic           last;
    logic           div_ovf;
    logic [M:0]     mul_sum;
    logic [M-1:0]   mul_hi, mul_lo;
    logic [M:0]     div_sh;
    logic           div_ge;
    logic [M-1:0]   div_diff;
    logic [M-1:0]   div_hi, div_lo;

    assign last    = (cnt == CW'(M - 1));
    // Overflow is decided on the untouched high half before the first shift.
    assign div_ovf = (state == S_DIV) && (cnt == '0) && (hi >= mcand);

    // MUL: {hi,lo} holds the partial product with the multiplier in lo, shifted right.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(M+1){1'b0}});
    assign mul_hi  = mul_sum[M:1];
    assign mul_lo  = {mul_sum[0], lo[M-1:1]};

    // DIV: hi is the running remainder, quotient bits shift into lo from the right.
    // The true difference is below mcand, so M-bit wraparound subtraction is exact.
    assign div_sh   = {hi, lo[M-1]};
    assign div_ge   = (div_sh >= {1'b0, mcand});
    assign div_diff = div_sh[M-1:0] - mcand;
    assign div_hi   = div_ge ? div_diff : div_sh[M-1:0];
    assign div_lo   = {lo[M-2:0], div_ge};

    assign busy = (state != S_IDLE);
    assign stop = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = op ? S_DIV : S_MUL;
            S_MUL:  if (last) state_nx = S_DONE;
            S_DIV:  if (div_ovf || last) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            sa       <= 1'b0;
            sv       <= 1'b0;
            sx       <= 1'b0;
            out_a    <= '0;
            out_x    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        sa    <= a[M];
                        sv    <= v[M];
                        sx    <= x[M];
                        mcand <= v[M-1:0];
                        hi    <= op ? a[M-1:0] : '0;
                        lo    <= op ? x[M-1:0] : a[M-1:0];
                    end
                end
                S_MUL: begin
                    hi  <= mul_hi;
                    lo  <= mul_lo;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        out_a    <= {sa ^ sv, mul_hi};
                        out_x    <= {sa ^ sv, mul_lo};
                        overflow <= 1'b0;
                    end
                end
                S_DIV: begin
                    if (div_ovf) begin
                        out_a    <= {sa, hi};
                        out_x    <= {sx, lo};
                        overflow <= 1'b1;
                    end else begin
                        hi  <= div_hi;
                        lo  <= div_lo;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            out_a    <= {sa ^ sv, div_lo};
                            out_x    <= {sa, div_hi};
                            overflow <= 1'b0;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_muldiv.sv
// Self-checking bench for mix_muldiv: vector table, random model-checked ops,
// hand-written start/reset corner sequences and an M=8 instance.
module tb_mix_muldiv;
    localparam int M = 30;
    localparam int W = M + 1;
    localparam logic [M-1:0] MAXM = 30'h3FFFFFFF;

    logic clk, reset, start, op;
    logic [W-1:0] a, x, v, out_a, out_x;
    logic busy, stop, overflow;

    logic start8, op8;
    logic [8:0] a8, x8, v8, out_a8, out_x8;
    logic busy8, stop8, overflow8;

    mix_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .x(x), .v(v),
        .busy(busy), .stop(stop), .out_a(out_a), .out_x(out_x), .overflow(overflow)
    );

    mix_muldiv #(.WORD_BYTES(2), .BYTE_BITS(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .x(x8), .v(v8),
        .busy(busy8), .stop(stop8), .out_a(out_a8), .out_x(out_x8), .overflow(overflow8)
    );

    typedef struct {
        logic [W-1:0] ea, ex;
        logic         eovf;
        int           lat;
        int           t0;
    } exp_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a, x, v, ea, ex;
        logic         eovf;
        int           lat;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   stop_cnt = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [W-1:0] w(input logic s, input logic [M-1:0] m);
        return {s, m};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    // reference model on plain integer arithmetic
    task automatic model(input logic mop, input logic [W-1:0] ma, input logic [W-1:0] mx,
                         input logic [W-1:0] mv, output exp_t e);
        logic [2*M-1:0] p, d, q, r;
        logic s;
        s = ma[M] ^ mv[M];
        e.t0 = 0;
        if (!mop) begin
            p = {{M{1'b0}}, ma[M-1:0]} * {{M{1'b0}}, mv[M-1:0]};
            e.ea = {s, p[2*M-1:M]};
            e.ex = {s, p[M-1:0]};
            e.eovf = 1'b0;
            e.lat = M + 1;
        end else if (ma[M-1:0] >= mv[M-1:0]) begin
            e.ea = ma;
            e.ex = mx;
            e.eovf = 1'b1;
            e.lat = 2;
        end else begin
            d = {ma[M-1:0], mx[M-1:0]};
            q = d / {{M{1'b0}}, mv[M-1:0]};
            r = d % {{M{1'b0}}, mv[M-1:0]};
            e.ea = {s, q[M-1:0]};
            e.ex = {ma[M], r[M-1:0]};
            e.eovf = 1'b0;
            e.lat = M + 1;
        end
    endtask

    // scoreboard: every stop pops one expected record
    always @(negedge clk) begin
        if (!reset && stop) begin
            exp_t e;
            stop_cnt++;
            check("stop_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_a", out_a, e.ea);
                check("out_x", out_x, e.ex);
                check("overflow", overflow, e.eovf);
                check("latency", 64'(cyc_cnt - e.t0), 64'(e.lat));
            end
        end
    end

    // driver tasks
    task automatic drive(input logic dop, input logic [W-1:0] da, input logic [W-1:0] dx,
                         input logic [W-1:0] dv);
        op = dop; a = da; x = dx; v = dv; start = 1'b1;
    endtask

    task automatic wait_stop();
        int n = 0;
        while (!stop && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stop_timeout", 64'(stop), 64'd1);
    endtask

    task automatic run_op(input logic dop, input logic [W-1:0] da, input logic [W-1:0] dx,
                          input logic [W-1:0] dv, input logic [W-1:0] ea,
                          input logic [W-1:0] ex, input logic eovf, input int lat);
        exp_t e;
        @(negedge clk);
        check("idle_before_start", busy, 1'b0);
        drive(dop, da, dx, dv);
        e.ea = ea; e.ex = ex; e.eovf = eovf; e.lat = lat; e.t0 = cyc_cnt;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", busy, 1'b1);
        wait_stop();
    endtask

    initial begin
        exp_t e;
        int t0, k, n, sc;
        logic [M-1:0] am, vm, xm;
        logic [W-1:0] ra, rx, rv;
        logic rop;

        tbl[0] = '{1'b0, w(0, 2), w(0, 0), w(1, 3), w(1, 0), w(1, 6), 1'b0, 31};
        tbl[1] = '{1'b0, w(0, MAXM), w(0, 0), w(1, MAXM), w(1, 30'h3FFFFFFE), w(1, 1), 1'b0, 31};
        tbl[2] = '{1'b0, w(0, 0), w(0, 0), w(0, 5), w(0, 0), w(0, 0), 1'b0, 31};
        tbl[3] = '{1'b1, w(0, 0), w(0, 17), w(0, 5), w(0, 3), w(0, 2), 1'b0, 31};
        tbl[4] = '{1'b1, w(1, 0), w(0, 17), w(0, 5), w(1, 3), w(1, 2), 1'b0, 31};
        tbl[5] = '{1'b1, w(0, 5), w(0, 0), w(0, 5), w(0, 5), w(0, 0), 1'b1, 2};
        tbl[6] = '{1'b1, w(0, 0), w(1, 9), w(0, 0), w(0, 0), w(1, 9), 1'b1, 2};
        tbl[7] = '{1'b1, w(1, 1), w(0, 0), w(0, 3), w(1, 357913941), w(1, 1), 1'b0, 31};
        tbl[8] = '{1'b1, w(0, 0), w(1, 17), w(1, 5), w(1, 3), w(0, 2), 1'b0, 31};
        tbl[9] = '{1'b0, w(1, 12345), w(0, 0), w(1, 1000), w(0, 0), w(0, 12345000), 1'b0, 31};

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; x = '0; v = '0;
        start8 = 1'b0; op8 = 1'b0; a8 = '0; x8 = '0; v8 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_stop", stop, 1'b0);
        check("rst_out_a", out_a, '0);
        check("rst_out_x", out_x, '0);
        check("rst_overflow", overflow, 1'b0);

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].x, tbl[i].v, tbl[i].ea, tbl[i].ex,
                   tbl[i].eovf, tbl[i].lat);

        // random operations checked against the integer model
        for (int i = 0; i < 8; i++) begin
            rop = 1'($urandom_range(0, 1));
            vm = M'($urandom_range(1, 32'h3FFFFFFF));
            am = rop ? M'($urandom_range(0, 32'(vm) - 1)) : M'($urandom_range(0, 32'h3FFFFFFF));
            xm = M'($urandom_range(0, 32'h3FFFFFFF));
            ra = {1'($urandom_range(0, 1)), am};
            rx = {1'($urandom_range(0, 1)), xm};
            rv = {1'($urandom_range(0, 1)), vm};
            model(rop, ra, rx, rv, e);
            run_op(rop, ra, rx, rv, e.ea, e.ex, e.eovf, e.lat);
        end

        // start pulses during MUL and in its stop cycle are ignored
        @(negedge clk);
        drive(1'b0, w(0, 7), w(0, 0), w(0, 9));
        t0 = cyc_cnt;
        e.ea = w(0, 0); e.ex = w(0, 63); e.eovf = 1'b0; e.lat = 31; e.t0 = t0;
        exp_q.push_back(e);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            k = cyc_cnt - t0;
            check("busy_window", busy, 1'(k >= 1 && k <= 31));
            check("stop_window", stop, 1'(k == 31));
            if (k == 5 || k == 20 || k == 31) drive(1'b1, w(1, 1), w(0, 0), w(0, 2));
            else start = 1'b0;
        end
        start = 1'b0;

        // reset in the middle of a DIV discards it
        @(negedge clk);
        drive(1'b1, w(0, 0), w(0, 100), w(0, 7));
        t0 = cyc_cnt;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cyc_cnt - t0 < 10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_stop", stop, 1'b0);
        check("mid_rst_out_a", out_a, '0);
        check("mid_rst_out_x", out_x, '0);
        check("mid_rst_overflow", overflow, 1'b0);
        sc = stop_cnt;
        repeat (40) @(negedge clk);
        check("no_stop_after_reset", 64'(stop_cnt), 64'(sc));
        run_op(1'b1, w(0, 0), w(0, 100), w(0, 7), w(0, 14), w(0, 2), 1'b0, 31);

        // M = 8 instance: 255 x 255
        @(negedge clk);
        op8 = 1'b0; a8 = 9'd255; x8 = 9'd0; v8 = 9'd255; start8 = 1'b1;
        t0 = cyc_cnt;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!stop8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("m8_stop", stop8, 1'b1);
        check("m8_latency", 64'(cyc_cnt - t0), 64'd9);
        check("m8_out_a", out_a8, 9'd254);
        check("m8_out_x", out_x8, 9'd1);
        check("m8_overflow", overflow8, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
